// File: rtl/disp_pkg.sv
// Shared types, default constants and digit-selection helpers for the display scan controller.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    localparam int DEF_PRESCALE_BITS = 8;
    localparam int DEF_DIGITS        = 4;
    localparam int DEF_BLANK_CYCLES  = 4;

    // Helpers work on a fixed wide mask so one function serves every DIGITS value.
    // IDX_W is one bit wider than needed so callers can always slice off spare bits.
    localparam int MAX_DIGITS = 32;
    localparam int IDX_W      = 6;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             wrap;
    } next_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_DIGITS-1:0] mask);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (mask[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // Lowest set bit strictly above cur; otherwise wrap to the lowest set bit overall.
    function automatic next_t next_digit(input logic [MAX_DIGITS-1:0] mask,
                                         input logic [IDX_W-1:0]      cur);
        next_t r;
        r.wrap = 1'b1;
        r.idx  = lowest_set(mask);
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (mask[i] && (IDX_W'(i) > cur)) begin
                r.idx  = IDX_W'(i);
                r.wrap = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Dwell prescaler: free-running up-counter with synchronous clear and a terminal-count flag.
module scan_prescaler #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins over count; the counter wraps naturally from all-ones to zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = &count_q;

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller: blank gap, then dwell on each enabled digit in turn.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int PRESCALE_BITS = DEF_PRESCALE_BITS,
    parameter int DIGITS        = DEF_DIGITS,
    parameter int BLANK_CYCLES  = DEF_BLANK_CYCLES
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic [DIGITS-1:0]                      digit_mask,
    output logic [DIGITS-1:0]                      an,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_sel,
    output logic                                   blank,
    output logic                                   frame_done
);

    localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int GAP_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BLANK_CYCLES - 1);

    scan_state_t      state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [SEL_W-1:0] digit_sel_q, digit_sel_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic             blank_q, blank_d;
    logic             frame_done_q, frame_done_d;

    logic             pre_tc;
    logic             pre_clr;
    logic             pre_en;
    next_t            nxt;
    logic [IDX_W-1:0] first_idx;
    logic             unused_idx_bits;

    // Prescaler only runs while driving; any other state (or disable) parks it at zero.
    assign pre_en  = (state_q == ST_DRIVE);
    assign pre_clr = !enable || (state_q != ST_DRIVE);

    scan_prescaler #(
        .WIDTH (PRESCALE_BITS)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (pre_clr),
        .en    (pre_en),
        .tc    (pre_tc)
    );

    assign nxt             = next_digit(MAX_DIGITS'(digit_mask), IDX_W'(digit_sel_q));
    assign first_idx       = lowest_set(MAX_DIGITS'(digit_mask));
    assign unused_idx_bits = ^{nxt.idx[IDX_W-1:SEL_W], first_idx[IDX_W-1:SEL_W]};

    // Next-state, gap counter, digit advance and wrap pulse; outputs are derived from the next state
    // so the registered anodes line up with the state they belong to.
    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        digit_sel_d  = digit_sel_q;
        frame_done_d = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            gap_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    gap_d = '0;
                    if (digit_mask != '0) begin
                        state_d     = ST_BLANK;
                        digit_sel_d = first_idx[SEL_W-1:0];
                    end
                end
                ST_BLANK: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = ST_DRIVE;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    gap_d = '0;
                    if (pre_tc) begin
                        if (digit_mask == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d      = ST_BLANK;
                            digit_sel_d  = nxt.idx[SEL_W-1:0];
                            frame_done_d = nxt.wrap;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end
            endcase
        end
        blank_d = (state_d != ST_DRIVE);
    end

    // One-hot active-low anode decode of the upcoming digit while driving.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
        assign an_d[gi] = !((state_d == ST_DRIVE) && (digit_sel_d == SEL_W'(gi)));
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            gap_q        <= '0;
            digit_sel_q  <= '0;
            an_q         <= '1;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            digit_sel_q  <= digit_sel_d;
            an_q         <= an_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign digit_sel  = digit_sel_q;
    assign blank      = blank_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with PRESCALE_BITS=3, BLANK_CYCLES=2, DIGITS=4 (10-cycle digit period).
module tb_disp_scan_ctrl;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] digit_mask;
    logic [3:0] an;
    logic [1:0] digit_sel;
    logic       blank;
    logic       frame_done;

    int n_checks;
    int n_errors;
    int multi_low;
    int blank_bad;

    // log[k] holds outputs sampled just after the k-th edge following the start edge E0 (log[0]).
    logic [3:0] an_log    [0:99];
    logic [1:0] sel_log   [0:99];
    logic       blank_log [0:99];
    logic       fd_log    [0:99];

    disp_scan_ctrl #(
        .PRESCALE_BITS (3),
        .DIGITS        (4),
        .BLANK_CYCLES  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digit_mask (digit_mask),
        .an         (an),
        .digit_sel  (digit_sel),
        .blank      (blank),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int start, input int n);
        for (int k = start; k < start + n; k++) begin
            step();
            an_log[k]    = an;
            sel_log[k]   = digit_sel;
            blank_log[k] = blank;
            fd_log[k]    = frame_done;
            if ($countones(~an) > 1) multi_low++;
            if (blank != (an == 4'b1111)) blank_bad++;
        end
    endtask

    // One disabled cycle to reach IDLE, then enable with a new mask; E0 is the next edge.
    task automatic restart(input logic [3:0] m);
        enable = 1'b0;
        step();
        digit_mask = m;
        enable     = 1'b1;
    endtask

    function automatic int pulses(input int a, input int b);
        int c;
        c = 0;
        for (int k = a; k <= b; k++) if (fd_log[k]) c++;
        return c;
    endfunction

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        multi_low  = 0;
        blank_bad  = 0;
        reset      = 1'b0;
        enable     = 1'b1;
        digit_mask = 4'b1111;

        // Reset held low with enable high.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_an", an, 4'b1111);
            chk("rst_blank", blank, 1'b1);
            chk("rst_sel", digit_sel, 2'd0);
            chk("rst_fd", frame_done, 1'b0);
        end
        $display("reset: %0d checks so far", n_checks);

        // Full scan, mask 1111.
        reset = 1'b1;
        capture(0, 81);
        chk("full_an0", an_log[0], 4'b1111);
        chk("full_sel0", sel_log[0], 2'd0);
        chk("full_an1", an_log[1], 4'b1111);
        chk("full_an2", an_log[2], 4'b1110);
        chk("full_an9", an_log[9], 4'b1110);
        chk("full_an10", an_log[10], 4'b1111);
        chk("full_an11", an_log[11], 4'b1111);
        chk("full_sel10", sel_log[10], 2'd1);
        chk("full_an12", an_log[12], 4'b1101);
        chk("full_an22", an_log[22], 4'b1011);
        chk("full_an32", an_log[32], 4'b0111);
        chk("full_an39", an_log[39], 4'b0111);
        chk("full_fd39", fd_log[39], 1'b0);
        chk("full_fd40", fd_log[40], 1'b1);
        chk("full_fd41", fd_log[41], 1'b0);
        chk("full_sel40", sel_log[40], 2'd0);
        chk("full_an42", an_log[42], 4'b1110);
        chk("full_fd80", fd_log[80], 1'b1);
        chk("full_pulses", pulses(0, 80), 2);
        $display("full scan mask=1111: %0d checks so far", n_checks);

        // Sparse mask 1010.
        restart(4'b1010);
        capture(0, 41);
        chk("sp_sel0", sel_log[0], 2'd1);
        chk("sp_an2", an_log[2], 4'b1101);
        chk("sp_sel10", sel_log[10], 2'd3);
        chk("sp_fd10", fd_log[10], 1'b0);
        chk("sp_an12", an_log[12], 4'b0111);
        chk("sp_fd20", fd_log[20], 1'b1);
        chk("sp_sel20", sel_log[20], 2'd1);
        chk("sp_an22", an_log[22], 4'b1101);
        chk("sp_fd40", fd_log[40], 1'b1);
        chk("sp_pulses", pulses(0, 40), 2);
        $display("sparse mask=1010: %0d checks so far", n_checks);

        // Single digit mask 0100: every advance wraps.
        restart(4'b0100);
        capture(0, 21);
        chk("one_sel0", sel_log[0], 2'd2);
        chk("one_an2", an_log[2], 4'b1011);
        chk("one_fd10", fd_log[10], 1'b1);
        chk("one_sel10", sel_log[10], 2'd2);
        chk("one_an12", an_log[12], 4'b1011);
        chk("one_fd20", fd_log[20], 1'b1);
        chk("one_pulses", pulses(0, 20), 2);
        $display("single mask=0100: %0d checks so far", n_checks);

        // Disable on the 5th drive cycle of digit 2, then restart at the lowest enabled digit.
        restart(4'b1111);
        capture(0, 27);
        chk("dis_an26", an_log[26], 4'b1011);
        enable = 1'b0;
        capture(27, 1);
        chk("dis_an27", an_log[27], 4'b1111);
        chk("dis_blank27", blank_log[27], 1'b1);
        chk("dis_sel27", sel_log[27], 2'd2);
        digit_mask = 4'b0110;
        enable     = 1'b1;
        capture(28, 3);
        chk("dis_sel28", sel_log[28], 2'd1);
        chk("dis_an28", an_log[28], 4'b1111);
        chk("dis_an29", an_log[29], 4'b1111);
        chk("dis_an30", an_log[30], 4'b1101);
        $display("disable mid-drive: %0d checks so far", n_checks);

        // Mask change mid-drive, then mask to zero before an advance.
        restart(4'b1111);
        capture(0, 15);
        chk("mc_an14", an_log[14], 4'b1101);
        digit_mask = 4'b0001;
        capture(15, 10);
        chk("mc_an19", an_log[19], 4'b1101);
        chk("mc_an20", an_log[20], 4'b1111);
        chk("mc_fd20", fd_log[20], 1'b1);
        chk("mc_sel20", sel_log[20], 2'd0);
        chk("mc_fd21", fd_log[21], 1'b0);
        chk("mc_an22", an_log[22], 4'b1110);
        digit_mask = 4'b0000;
        capture(25, 8);
        chk("mz_an29", an_log[29], 4'b1110);
        chk("mz_an30", an_log[30], 4'b1111);
        chk("mz_fd30", fd_log[30], 1'b0);
        chk("mz_fd31", fd_log[31], 1'b0);
        chk("mz_an32", an_log[32], 4'b1111);
        $display("mask change / mask zero: %0d checks so far", n_checks);

        // Enable dropped on the terminal-count cycle of the last digit.
        restart(4'b1111);
        capture(0, 40);
        chk("col_an39", an_log[39], 4'b0111);
        enable = 1'b0;
        capture(40, 2);
        chk("col_fd40", fd_log[40], 1'b0);
        chk("col_an40", an_log[40], 4'b1111);
        chk("col_blank40", blank_log[40], 1'b1);
        chk("col_sel40", sel_log[40], 2'd3);
        chk("col_fd41", fd_log[41], 1'b0);
        $display("enable/terminal-count collision: %0d checks so far", n_checks);

        // Reset asserted mid-drive.
        restart(4'b1111);
        capture(0, 14);
        chk("rd_an13", an_log[13], 4'b1101);
        reset = 1'b0;
        capture(14, 1);
        chk("rd_an14", an_log[14], 4'b1111);
        chk("rd_sel14", sel_log[14], 2'd0);
        chk("rd_blank14", blank_log[14], 1'b1);
        reset = 1'b1;
        $display("reset mid-drive: %0d checks so far", n_checks);

        // Invariants accumulated over every captured cycle.
        chk("inv_multi_low", multi_low, 0);
        chk("inv_blank", blank_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed display scan controller for the calculator's multi-digit 7-segment output. It owns one free-running prescaler counter and sequences it to dwell on each enabled digit for a fixed number of cycles. Between digits it inserts a short blanking gap to prevent ghosting. It sits between the result/format logic, which supplies the digit mask and consumes `digit_sel`, and the board-level anode pins.

## Interface
- `PRESCALE_BITS`, default 8: width of the dwell prescaler; DRIVE phase lasts exactly 2**PRESCALE_BITS cycles.
- `DIGITS`, default 4: number of digit positions, ≥ 1.
- `BLANK_CYCLES`, default 4: length of the all-off gap before each digit, ≥ 1.
- `SEL_W`: derived localparam, not overridable; max($clog2(DIGITS),1).

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  scan enable; low forces IDLE.
- `digit_mask`  in  DIGITS  1 = digit lit; sampled at scan start and at each digit advance.
- `an`  out  DIGITS  active-low anode drive, registered.
- `digit_sel`  out  SEL_W  index of current/next digit, registered; segment mux select.
- `blank`  out  1  high whenever no anode is driven, registered.
- `frame_done`  out  1  one-cycle pulse when scan wraps past last enabled digit.

## Operation
- States: IDLE, BLANK, DRIVE.
- IDLE:
  - Outputs are `an`=all 1, `blank`=1, prescaler held at 0, and `digit_sel` holds its value.
  - Go to BLANK when `enable`=1 and `digit_mask`≠0.
  - `digit_sel` loads the lowest set mask bit.
- BLANK:
  - `an`=all 1 and `blank`=1; gap counter runs 0..BLANK_CYCLES-1.
  - At the last count, go to DRIVE.
- DRIVE:
  - `an[digit_sel]`=0, all other bits 1, `blank`=0.
  - Prescaler increments every cycle.
  - At terminal count (all ones), prescaler wraps to 0 and the FSM returns to BLANK.
  - `digit_sel` advances to the next enabled digit, using the current `digit_mask`.
- Next-digit rule:
  - Take the lowest set bit strictly above `digit_sel`.
  - If none exists, take the lowest set bit overall. This is a wrap; pulse `frame_done` in the same cycle as the transition.
  - With a single enabled digit, every advance is a wrap.
- Mask going to 0 at an advance: go to IDLE instead of BLANK; no `frame_done`.
- Mask changes mid-DRIVE do not affect the lit digit until the next advance.
- `enable`=0 in any state: IDLE next cycle, and all counters clear.
- `enable` has priority over a simultaneous terminal count, so no `frame_done` is produced.
- `reset`=0 overrides everything, including mid-DRIVE.

## Timing
- Reset values: `an`=all 1, `digit_sel`=0, `blank`=1, `frame_done`=0; state IDLE; prescaler and gap counter 0.
- Start-up: `enable` sampled high at edge E0 gives BLANK from E0. The first low anode appears after edge E0+BLANK_CYCLES.
- Digit period is exactly BLANK_CYCLES + 2**PRESCALE_BITS cycles (260 at defaults).
- Frame period is N × digit period, where N = popcount(`digit_mask`).
- `frame_done` is high for exactly one cycle, coincident with the first BLANK cycle of the wrapped-to digit.
- `an` never has more than one bit low in any cycle.
- Every anode change passes through at least BLANK_CYCLES all-high cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `disp_pkg` holds:
  - the state enum (IDLE/BLANK/DRIVE);
  - the default parameter constants;
  - a `next_digit(mask, cur)` function, returning index and wrap flag.
- One sub-module, `scan_prescaler`:
  - PRESCALE_BITS up-counter with enable and synchronous clear;
  - exports a terminal-count flag (count == 2**PRESCALE_BITS-1).
- The FSM, gap counter and output registers live in `disp_scan_ctrl`.

## Test plan
All scenarios use PRESCALE_BITS=3, BLANK_CYCLES=2, DIGITS=4, so the digit period is 10 cycles.

- **Reset:** hold `reset`=0 for 3 cycles with `enable`=1 → `an`=4'b1111, `blank`=1, `digit_sel`=0, `frame_done`=0 throughout.
- **Full scan, mask=4'b1111:**
  - `an` sequence is 1110, 1101, 1011, 0111, each low for 8 cycles, separated by 2 cycles of 1111.
  - `frame_done` pulses every 40 cycles.
- **Sparse mask=4'b1010:**
  - Only digits 1 and 3 are lit; `digit_sel` alternates 1, 3.
  - `frame_done` pulses every 20 cycles.
  - Mask=4'b0100 gives a pulse every 10 cycles.
- **Disable mid-DRIVE** (5th drive cycle of digit 2) → IDLE next cycle, `an`=1111. Re-enable → restart at the lowest enabled digit after 2 blank cycles.
- **Mask change and mask-to-zero:**
  - Change mask 1111→0001 mid-DRIVE on digit 1 → digit 1 completes its 8 cycles, then wrap to digit 0 with `frame_done`.
  - Mask→0 before an advance → IDLE, no pulse.
- **Enable/terminal-count collision:** drop `enable` on the terminal-count cycle of the last digit → IDLE with `frame_done`=0.
